// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/freeze sequencing and EX forwarding selects for the 5-stage pipe
// Optional HAZ_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_wr,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_wr,
  input  logic                  i_br_taken,
  input  logic                  i_mem_ready,
  output logic                  o_pc_wr_en,
  output logic                  o_if_id_wr_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_bubble,
  output logic                  o_pipe_freeze,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_flush_events
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

  localparam logic [2:0] FLUSH_N = 3'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic load_use;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  assign load_use = i_ex_mem_read & i_ex_reg_wr & (i_ex_rd != '0) &
                    ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                     (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // A load in EX has no result yet, so it is never a forwarding source.
  assign ex_hit_a  = i_ex_reg_wr & ~i_ex_mem_read & (i_ex_rd != '0) & i_id_use_rs1 & (i_ex_rd == i_id_rs1);
  assign ex_hit_b  = i_ex_reg_wr & ~i_ex_mem_read & (i_ex_rd != '0) & i_id_use_rs2 & (i_ex_rd == i_id_rs2);
  assign mem_hit_a = i_mem_reg_wr & (i_mem_rd != '0) & i_id_use_rs1 & (i_mem_rd == i_id_rs1);
  assign mem_hit_b = i_mem_reg_wr & (i_mem_rd != '0) & i_id_use_rs2 & (i_mem_rd == i_id_rs2);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    o_pc_wr_en     = 1'b1;
    o_if_id_wr_en  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_freeze  = 1'b0;
    if (i_rst) begin
      if (!i_mem_ready) begin
        o_pipe_freeze = 1'b1;
        o_pc_wr_en    = 1'b0;
        o_if_id_wr_en = 1'b0;
        state_d       = ST_MEM_WAIT;
        if (i_br_taken) pend_d = 1'b1;
      end else if (i_br_taken) begin
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
        pend_d         = 1'b0;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_N - 3'd1;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end else if (state_q == ST_FLUSH) begin
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end else begin
        // The cycle leaving MEM_WAIT behaves as a RUN cycle for load-use.
        if (state_q == ST_MEM_WAIT) begin
          pend_d = 1'b0;
          if (pend_q) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_N;
          end else begin
            state_d = ST_RUN;
          end
        end
        if (load_use) begin
          o_pc_wr_en     = 1'b0;
          o_if_id_wr_en  = 1'b0;
          o_id_ex_bubble = 1'b1;
        end
      end
      if (i_mem_ready) begin
        fwd_a_d = o_id_ex_bubble ? 2'b00 : (ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00));
        fwd_b_d = o_id_ex_bubble ? 2'b00 : (ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign o_fwd_a = fwd_a_q;
  assign o_fwd_b = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flev_q;
  logic        flush_evt;

  // A branch accepted while frozen is counted when the pending flush launches.
  assign flush_evt = i_mem_ready & (i_br_taken | ((state_q == ST_MEM_WAIT) & pend_q));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
      flev_q  <= '0;
    end else begin
      if (!o_pc_wr_en && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (flush_evt && (flev_q != 32'hFFFF_FFFF))    flev_q  <= flev_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flush_events = flev_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl with a cycle-level reference model
module tb_hazard_ctrl;

  localparam int FC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       use1, use2, ex_reg_wr, ex_mem_read, mem_reg_wr, br, mem_ready;
  logic       pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] m_stall, m_fev;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_rd(ex_rd), .i_ex_reg_wr(ex_reg_wr), .i_ex_mem_read(ex_mem_read),
    .i_mem_rd(mem_rd), .i_mem_reg_wr(mem_reg_wr),
    .i_br_taken(br), .i_mem_ready(mem_ready),
    .o_pc_wr_en(pc_wr_en), .o_if_id_wr_en(if_id_wr_en), .o_if_id_flush(if_id_flush),
    .o_id_ex_bubble(id_ex_bubble), .o_pipe_freeze(pipe_freeze),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
`endif
  );

  // Model state: waiting on memory, branch owed after the wait, flush cycles owed.
  logic       m_wait, m_pend;
  int         m_left;
  logic [1:0] m_fa, m_fb;

  logic m_flushing, lu_cond, e_freeze, e_flush, e_stall, e_bubble, e_pc;
  assign m_flushing = !m_wait && (m_left > 0);
  assign lu_cond    = ex_mem_read && ex_reg_wr && (ex_rd != 0) &&
                      ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
  assign e_freeze   = rst_n && !mem_ready;
  assign e_flush    = rst_n && mem_ready && (br || m_flushing);
  assign e_stall    = rst_n && mem_ready && !br && !m_flushing && lu_cond;
  assign e_bubble   = e_flush || e_stall;
  assign e_pc       = !e_freeze && !e_stall;

  function automatic logic [1:0] pick(input logic [4:0] rs, input logic u,
                                      input logic [4:0] erd, input logic ewr, input logic eld,
                                      input logic [4:0] mrd, input logic mwr);
    if (u && rs != 0 && ewr && !eld && erd == rs) return 2'b01;
    if (u && rs != 0 && mwr && mrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 1'b0; m_pend <= 1'b0; m_left <= 0; m_fa <= 2'b00; m_fb <= 2'b00;
`ifdef HAZ_PERF_CNT_EN
      m_stall <= 0; m_fev <= 0;
`endif
    end else begin
      if (mem_ready) begin
        m_fa <= e_bubble ? 2'b00 : pick(rs1, use1, ex_rd, ex_reg_wr, ex_mem_read, mem_rd, mem_reg_wr);
        m_fb <= e_bubble ? 2'b00 : pick(rs2, use2, ex_rd, ex_reg_wr, ex_mem_read, mem_rd, mem_reg_wr);
      end
`ifdef HAZ_PERF_CNT_EN
      if (!e_pc) m_stall <= m_stall + 1;
      if (mem_ready && (br || (m_wait && m_pend))) m_fev <= m_fev + 1;
`endif
      if (!mem_ready) begin
        m_wait <= 1'b1;
        if (br) m_pend <= 1'b1;
      end else if (br) begin
        m_wait <= 1'b0; m_pend <= 1'b0; m_left <= FC - 1;
      end else if (m_wait) begin
        m_wait <= 1'b0; m_pend <= 1'b0; m_left <= m_pend ? FC : 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("pc_wr_en", 32'(pc_wr_en), 32'(e_pc));
    check("if_id_wr_en", 32'(if_id_wr_en), 32'(e_pc));
    check("if_id_flush", 32'(if_id_flush), 32'(e_flush));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bubble));
    check("pipe_freeze", 32'(pipe_freeze), 32'(e_freeze));
    check("fwd_a", 32'(fwd_a), 32'(m_fa));
    check("fwd_b", 32'(fwd_b), 32'(m_fb));
`ifdef HAZ_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_events", flush_events, m_fev);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
    ex_rd = 0; ex_reg_wr = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_wr = 0; br = 0; mem_ready = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst pc_wr_en", 32'(pc_wr_en), 1);
    check("rst if_id_wr_en", 32'(if_id_wr_en), 1);
    check("rst flush", 32'(if_id_flush), 0);
    check("rst bubble", 32'(id_ex_bubble), 0);
    check("rst freeze", 32'(pipe_freeze), 0);
    check("rst fwd_a", 32'(fwd_a), 0);
    check("rst fwd_b", 32'(fwd_b), 0);
    rst_n = 1'b1;

    // load x5 in EX, ID reads x5
    ex_mem_read = 1; ex_reg_wr = 1; ex_rd = 5; rs1 = 5; use1 = 1;
    #1;
    check("lu pc_wr_en", 32'(pc_wr_en), 0);
    check("lu if_id_wr_en", 32'(if_id_wr_en), 0);
    check("lu bubble", 32'(id_ex_bubble), 1);
    cyc();
    check("lu fwd_a bubble", 32'(fwd_a), 0);
    ex_mem_read = 0; ex_reg_wr = 0; ex_rd = 0; mem_rd = 5; mem_reg_wr = 1;
    #1;
    check("lu released pc", 32'(pc_wr_en), 1);
    cyc();
    check("lu fwd_a mem", 32'(fwd_a), 2);

    // forwarding priority on rs2
    clear_in();
    ex_rd = 3; ex_reg_wr = 1; mem_rd = 3; mem_reg_wr = 1; rs2 = 3; use2 = 1;
    cyc();
    check("fwd_b ex", 32'(fwd_b), 1);
    ex_reg_wr = 0;
    cyc();
    check("fwd_b mem", 32'(fwd_b), 2);
    rs2 = 0; ex_rd = 0; mem_rd = 0; ex_reg_wr = 1; ex_mem_read = 1;
    #1;
    check("x0 no stall", 32'(pc_wr_en), 1);
    check("x0 no bubble", 32'(id_ex_bubble), 0);
    cyc();
    check("fwd_b x0", 32'(fwd_b), 0);

    // taken branch, FC flush cycles
    clear_in();
    br = 1;
    for (int i = 0; i < FC; i++) begin
      #1;
      check("br flush", 32'(if_id_flush), 1);
      check("br bubble", 32'(id_ex_bubble), 1);
      check("br pc", 32'(pc_wr_en), 1);
      cyc();
      br = 0;
    end
    #1;
    check("br done flush", 32'(if_id_flush), 0);
`ifdef HAZ_PERF_CNT_EN
    check("perf stall", stall_cycles, 1);
    check("perf flush", flush_events, 1);
`endif

    // memory wait with a branch arriving mid-wait
    clear_in();
    ex_rd = 7; ex_reg_wr = 1; rs1 = 7; use1 = 1;
    cyc();
    check("pre-wait fwd_a", 32'(fwd_a), 1);
    mem_ready = 0; rs1 = 0;
    for (int i = 0; i < 4; i++) begin
      br = (i == 1);
      #1;
      check("wait freeze", 32'(pipe_freeze), 1);
      check("wait pc", 32'(pc_wr_en), 0);
      check("wait fwd_a hold", 32'(fwd_a), 1);
      cyc();
    end
    clear_in();
    cyc();
    for (int i = 0; i < FC; i++) begin
      #1;
      check("pending flush", 32'(if_id_flush), 1);
      check("pending pc", 32'(pc_wr_en), 1);
      cyc();
    end
    #1;
    check("pending done", 32'(if_id_flush), 0);

    // async reset during FLUSH
    clear_in();
    br = 1;
    cyc();
    br = 0;
    #2 rst_n = 1'b0;
    #1;
    check("mid rst pc", 32'(pc_wr_en), 1);
    check("mid rst flush", 32'(if_id_flush), 0);
    check("mid rst bubble", 32'(id_ex_bubble), 0);
    check("mid rst freeze", 32'(pipe_freeze), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post rst flush", 32'(if_id_flush), 0);

    // reset discards a pending branch
    mem_ready = 0; br = 1;
    cyc();
    br = 0;
    #2 rst_n = 1'b0;
    #1;
    check("pend rst freeze", 32'(pipe_freeze), 0);
    cyc();
    rst_n = 1'b1; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pend discarded", 32'(if_id_flush), 0);
    end

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
